wb_sched: RTL and testbench
===========================

Name: wb_sched

Overview:
- Writeback scheduler and scoreboard for the 32x32 two-read/one-write register file (`regs`).
- Shares the single write port between two writeback requesters, the ALU (`a_*`) and the load unit (`m_*`), using round-robin arbitration.
- Keeps a busy bit per register for every issued destination. Decode uses these bits for RAW and WAW stalls.
- Sits between issue/decode, the execution units and the `wr_en`/`rd`/`rd_val` port of `regs`.

Parameters:
- W, 32, writeback data width; must match `regs` W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- iss_valid  in  1  decode wants to issue an instruction that writes iss_rd
- iss_rd  in  5  destination register of the issuing instruction
- iss_ready  out  1  issue accepted this cycle
- chk_rs1  in  5  source register 1 to hazard-check
- chk_rs2  in  5  source register 2 to hazard-check
- rs1_busy  out  1  chk_rs1 has a pending write
- rs2_busy  out  1  chk_rs2 has a pending write
- a_valid  in  1  ALU writeback request
- a_rd  in  5  ALU destination register
- a_val  in  W  ALU result
- a_ready  out  1  ALU request granted
- m_valid  in  1  load-unit writeback request
- m_rd  in  5  load destination register
- m_val  in  W  load data
- m_ready  out  1  load request granted
- wr_en  out  1  regfile write enable (registered)
- rd  out  5  regfile write address (registered)
- rd_val  out  W  regfile write data (registered)
- busy_cnt  out  6  number of set busy bits, 0..31
- err  out  1  sticky protocol error

Behaviour:
- Reset:
  - Applied on a clk edge with rst=1.
  - Clears busy[31:0], the round-robin pointer (favours ALU next), wr_en, rd, rd_val, busy_cnt and err.
  - In-flight requests are discarded; requesters must re-present them after reset.
- Scoreboard:
  - busy[0] is hard-wired 0.
  - rsN_busy = busy[chk_rsN], combinational.
- Issue:
  - iss_ready = !rst && (iss_rd==0 || !busy[iss_rd]), combinational.
  - On iss_valid && iss_ready with iss_rd!=0, busy[iss_rd] is set at the next edge.
- Arbitration:
  - Combinational; the write port accepts every cycle, so there is no backpressure beyond arbitration.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last time wins. The pointer updates only on a two-way conflict grant.
  - ready is asserted only while the requester is valid. A request is transferred on valid && ready.
  - Requesters hold valid/rd/val stable until ready.
- Output stage, for a grant at cycle t:
  - wr_en=1, rd=granted rd, rd_val=granted val in cycle t+1.
  - If the granted rd is 0, the request is accepted but wr_en stays 0 (write dropped).
  - With no grant, wr_en=0 next cycle; rd and rd_val hold their last value.
- Busy clear:
  - busy[rd] clears at the end of the cycle in which wr_en=1 (edge t+2), i.e. the same edge `regs` commits the write.
  - From cycle t+2, rsN_busy=0 and a read issued then returns the new value.
- Simultaneous set and clear of the same register:
  - Cannot happen via issue, because iss_ready is low while the bit is busy.
  - If forced anyway, the set wins.
- Same-cycle issue and writeback to different registers: both take effect independently.
- Error:
  - err is set on a granted writeback with rd!=0 whose busy bit is clear (unissued write).
  - err stays set until rst. The write is still performed.
- busy_cnt is registered and equals popcount(busy) after each edge.

Optional Feature:
- Macro WB_SCHED_BYPASS_EN.
- Defined:
  - Adds outputs fwd_rs1_hit (1), fwd_rs2_hit (1) and fwd_val (W).
  - fwd_rsN_hit = wr_en && rd!=0 && rd==chk_rsN.
  - fwd_val = rd_val.
  - rsN_busy = busy[chk_rsN] && !fwd_rsN_hit, so dependents may proceed one cycle early using fwd_val captured that cycle.
- Undefined: these ports are absent and rsN_busy = busy[chk_rsN].

Decomposition:
- Package `regs_pkg`:
  - REG_AW=5, NREGS=32, REG_ZERO=5'd0.
  - WB_REQ_ALU=0, WB_REQ_MEM=1.
  - Typedef for the writeback request {valid, rd, val}.
- Sub-module `rr_arb2`:
  - Two-way round-robin arbiter with grant outputs and pointer register.
  - Reused later for the memory bus.

Test Plan:
- Issue x5 with iss_valid=1, iss_rd=5 -> next cycle rs1_busy=1 for chk_rs1=5, busy_cnt=1. Re-issue x5 -> iss_ready=0 (WAW stall).
- ALU writeback x5=0xDEADBEEF at cycle t -> wr_en=1, rd=5, rd_val=0xDEADBEEF at t+1. rs1_busy=0 at t+2, and a `regs` read at t+2 returns 0xDEADBEEF.
- Issue x3 and x4. a_valid(x3) and m_valid(x4) in the same cycle -> ALU granted first, load next cycle. Repeat the conflict -> load granted first (alternation).
- Writeback to x0 -> a_ready=1, wr_en stays 0, err=0. Writeback to unissued x7 -> wr_en=1 and err=1 sticky.
- Issue x1, x2, x9, then assert rst for one edge mid-writeback -> busy_cnt=0, wr_en=0, err=0, iss_ready=1 for x1.
- With WB_SCHED_BYPASS_EN: while wr_en=1, rd=5, rd_val=0x1234, set chk_rs2=5 -> fwd_rs2_hit=1, fwd_val=0x1234, rs2_busy=0.

Source files
------------

// File: rtl/regs_pkg.sv
// Register-file constants, writeback request type and arbiter pointer type
// shared by wb_sched and rr_arb2.
package regs_pkg;

  localparam int REG_AW = 5;
  localparam int NREGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_MEM = 1;

  localparam int WB_W = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [WB_W-1:0]   val;
  } wb_req_t;

  typedef enum logic {
    RR_FAV0 = 1'b0,
    RR_FAV1 = 1'b1
  } rr_ptr_t;

  function automatic logic [5:0] popcount(input logic [NREGS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NREGS; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves only when
// both requesters collide so the loser of a conflict wins the next one.
module rr_arb2
  import regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  rr_ptr_t ptr;

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] && (!req[1] || ptr == RR_FAV0);
    grant[1] = req[1] && !grant[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= RR_FAV0;
    end else if (&req) begin
      ptr <= grant[0] ? RR_FAV1 : RR_FAV0;
    end
  end

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler and busy-bit scoreboard for the 32x32 register file.
// Define WB_SCHED_BYPASS_EN to add the fwd_* forwarding outputs.
module wb_sched
  import regs_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [W-1:0]      a_val,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [REG_AW-1:0] m_rd,
  input  logic [W-1:0]      m_val,
  output logic              m_ready,
  output logic              wr_en,
  output logic [REG_AW-1:0] rd,
  output logic [W-1:0]      rd_val,
  output logic [5:0]        busy_cnt,
  output logic              err
`ifdef WB_SCHED_BYPASS_EN
  ,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit,
  output logic [W-1:0]      fwd_val
`endif
);

  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  wb_req_t           req [2];
  logic [1:0]        req_v;
  logic [1:0]        grant;
  logic              win;
  logic [REG_AW-1:0] sel_rd;
  logic [WB_W-1:0]   sel_val;
  logic              issue_set;

  always_comb begin
    req[WB_REQ_ALU]   = '{valid: a_valid, rd: a_rd, val: WB_W'(a_val)};
    req[WB_REQ_MEM]   = '{valid: m_valid, rd: m_rd, val: WB_W'(m_val)};
    req_v             = 2'b00;
    req_v[WB_REQ_ALU] = req[WB_REQ_ALU].valid;
    req_v[WB_REQ_MEM] = req[WB_REQ_MEM].valid;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_v),
    .grant (grant)
  );

  // Ready is withheld during reset so a discarded request is re-presented.
  assign a_ready = grant[WB_REQ_ALU] && !rst;
  assign m_ready = grant[WB_REQ_MEM] && !rst;
  assign win     = |grant;
  assign sel_rd  = grant[WB_REQ_MEM] ? req[WB_REQ_MEM].rd  : req[WB_REQ_ALU].rd;
  assign sel_val = grant[WB_REQ_MEM] ? req[WB_REQ_MEM].val : req[WB_REQ_ALU].val;

  assign iss_ready = !rst && (iss_rd == REG_ZERO || !busy[iss_rd]);
  assign issue_set = iss_valid && iss_ready && iss_rd != REG_ZERO;

`ifdef WB_SCHED_BYPASS_EN
  assign fwd_rs1_hit = wr_en && rd != REG_ZERO && rd == chk_rs1;
  assign fwd_rs2_hit = wr_en && rd != REG_ZERO && rd == chk_rs2;
  assign fwd_val     = rd_val;
  assign rs1_busy    = busy[chk_rs1] && !fwd_rs1_hit;
  assign rs2_busy    = busy[chk_rs2] && !fwd_rs2_hit;
`else
  assign rs1_busy = busy[chk_rs1];
  assign rs2_busy = busy[chk_rs2];
`endif

  // Clear for the committing write first, then issue, so a forced set wins.
  always_comb begin
    busy_next = busy;
    if (wr_en) busy_next[rd] = 1'b0;
    if (issue_set) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      wr_en    <= 1'b0;
      rd       <= REG_ZERO;
      rd_val   <= '0;
      err      <= 1'b0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= popcount(busy_next);
      wr_en    <= win && sel_rd != REG_ZERO;
      if (win) begin
        rd     <= sel_rd;
        rd_val <= W'(sel_val);
      end
      if (win && sel_rd != REG_ZERO && !busy[sel_rd]) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_sched.sv
// Self-checking bench for wb_sched: directed scenarios plus a randomized run
// against a behavioural scoreboard model. Honours WB_SCHED_BYPASS_EN.
module tb_wb_sched;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_val;
  logic        a_ready;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  logic        m_ready;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] rd_val;
  logic [5:0]  busy_cnt;
  logic        err;
`ifdef WB_SCHED_BYPASS_EN
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_val;
`endif

  int tests_run;
  int tests_failed;

  // Reference model state
  bit          mbusy [32];
  logic        mwr;
  logic [4:0]  mrd;
  logic [31:0] mval;
  logic        merr;
  bit          mfav_alu;

  wb_sched #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_val     (a_val),
    .a_ready   (a_ready),
    .m_valid   (m_valid),
    .m_rd      (m_rd),
    .m_val     (m_val),
    .m_ready   (m_ready),
    .wr_en     (wr_en),
    .rd        (rd),
    .rd_val    (rd_val),
    .busy_cnt  (busy_cnt),
    .err       (err)
`ifdef WB_SCHED_BYPASS_EN
    ,
    .fwd_rs1_hit (fwd_rs1_hit),
    .fwd_rs2_hit (fwd_rs2_hit),
    .fwd_val     (fwd_val)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic iv, input logic [4:0] ird,
                               input logic av, input logic [4:0] ard, input logic [31:0] aval,
                               input logic mv, input logic [4:0] mrdi, input logic [31:0] mvali);
    iss_valid = iv;
    iss_rd    = ird;
    a_valid   = av;
    a_rd      = ard;
    a_val     = aval;
    m_valid   = mv;
    m_rd      = mrdi;
    m_val     = mvali;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    tests_run++;
    if (iss_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_iss_ready_low: got %b want 0", iss_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (busy_cnt !== 6'd0 || wr_en !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: busy_cnt=%0d wr_en=%b err=%b want 0/0/0", busy_cnt, wr_en, err);
    end
    tests_run++;
    if (iss_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_iss_ready: got %b want 1", iss_ready);
    end
  endtask

  task automatic test_issue_waw();
    chk_rs1 = 5'd5;
    chk_rs2 = 5'd0;
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (iss_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL issue_ready: got %b want 1", iss_ready);
    end
    tick();
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (rs1_busy !== 1'b1 || busy_cnt !== 6'd1) begin
      tests_failed++;
      $display("[TB] FAIL issue_busy: rs1_busy=%b busy_cnt=%0d want 1/1", rs1_busy, busy_cnt);
    end
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (iss_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL waw_stall: iss_ready=%b want 0", iss_ready);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_writeback();
    logic exp_busy_t1;
    applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    tests_run++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wb_grant: a_ready=%b m_ready=%b want 1/0", a_ready, m_ready);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (wr_en !== 1'b1 || rd !== 5'd5 || rd_val !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL wb_port: wr_en=%b rd=%0d rd_val=%h want 1/5/deadbeef", wr_en, rd, rd_val);
    end
`ifdef WB_SCHED_BYPASS_EN
    exp_busy_t1 = 1'b0;
`else
    exp_busy_t1 = 1'b1;
`endif
    tests_run++;
    if (rs1_busy !== exp_busy_t1 || busy_cnt !== 6'd1) begin
      tests_failed++;
      $display("[TB] FAIL wb_busy_t1: rs1_busy=%b busy_cnt=%0d want %b/1", rs1_busy, busy_cnt, exp_busy_t1);
    end
    tick();
    tests_run++;
    if (rs1_busy !== 1'b0 || busy_cnt !== 6'd0 || wr_en !== 1'b0 || rd_val !== 32'hDEADBEEF || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wb_clear_t2: rs1_busy=%b cnt=%0d wr_en=%b rd_val=%h err=%b want 0/0/0/deadbeef/0",
               rs1_busy, busy_cnt, wr_en, rd_val, err);
    end
  endtask

  task automatic test_conflict();
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
    tests_run++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL conflict1_first: a_ready=%b m_ready=%b want 1/0", a_ready, m_ready);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'h44);
    tests_run++;
    if (m_ready !== 1'b1 || wr_en !== 1'b1 || rd !== 5'd3 || rd_val !== 32'h33) begin
      tests_failed++;
      $display("[TB] FAIL conflict1_second: m_ready=%b wr_en=%b rd=%0d val=%h want 1/1/3/33", m_ready, wr_en, rd, rd_val);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (wr_en !== 1'b1 || rd !== 5'd4 || rd_val !== 32'h44) begin
      tests_failed++;
      $display("[TB] FAIL conflict1_load_wb: wr_en=%b rd=%0d val=%h want 1/4/44", wr_en, rd, rd_val);
    end
    tick();
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 3, 32'h333, 1, 4, 32'h444);
    tests_run++;
    if (a_ready !== 1'b0 || m_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL conflict2_alternate: a_ready=%b m_ready=%b want 0/1", a_ready, m_ready);
    end
    tick();
    applyStimulus(0, 0, 1, 3, 32'h333, 0, 0, 0);
    tests_run++;
    if (a_ready !== 1'b1 || rd !== 5'd4 || rd_val !== 32'h444) begin
      tests_failed++;
      $display("[TB] FAIL conflict2_second: a_ready=%b rd=%0d val=%h want 1/4/444", a_ready, rd, rd_val);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tests_run++;
    if (busy_cnt !== 6'd0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL conflict_drain: busy_cnt=%0d err=%b want 0/0", busy_cnt, err);
    end
  endtask

  task automatic test_x0_unissued();
    applyStimulus(0, 0, 1, 0, 32'hAAAA, 0, 0, 0);
    tests_run++;
    if (a_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL x0_ready: got %b want 1", a_ready);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (wr_en !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL x0_drop: wr_en=%b err=%b want 0/0", wr_en, err);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'h77);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (wr_en !== 1'b1 || rd !== 5'd7 || err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL unissued_err: wr_en=%b rd=%0d err=%b want 1/7/1", wr_en, rd, err);
    end
    tick(); tick();
    tests_run++;
    if (err !== 1'b1 || busy_cnt !== 6'd0) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky: err=%b busy_cnt=%0d want 1/0", err, busy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 2, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 9, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 1, 32'h11, 0, 0, 0);
    tests_run++;
    if (busy_cnt !== 6'd3) begin
      tests_failed++;
      $display("[TB] FAIL mid_cnt: busy_cnt=%0d want 3", busy_cnt);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 2, 32'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (busy_cnt !== 6'd0 || wr_en !== 1'b0 || err !== 1'b0 || iss_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: cnt=%0d wr_en=%b err=%b iss_ready=%b want 0/0/0/1",
               busy_cnt, wr_en, err, iss_ready);
    end
  endtask

`ifdef WB_SCHED_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 5, 32'h1234, 0, 0, 0); tick();
    chk_rs2 = 5'd5;
    chk_rs1 = 5'd6;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (fwd_rs2_hit !== 1'b1 || fwd_val !== 32'h1234 || rs2_busy !== 1'b0 || fwd_rs1_hit !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bypass: hit2=%b val=%h rs2_busy=%b hit1=%b want 1/1234/0/0",
               fwd_rs2_hit, fwd_val, rs2_busy, fwd_rs1_hit);
    end
    tick();
  endtask
`endif

  function automatic logic [4:0] pick_rd();
    int s;
    s = $urandom_range(1, 31);
    if ($urandom_range(0, 9) < 8) begin
      for (int i = 0; i < 32; i++) begin
        if (mbusy[(s + i) % 32]) return 5'((s + i) % 32);
      end
    end
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic test_random();
    logic e_iss, e_rs1, e_rs2, e_a, e_m, g_any, a_fire, m_fire;
    logic [4:0] g_rd;
    logic [31:0] g_val;
    bit ob [32];
    int cnt;
    do_reset();
    for (int i = 0; i < 32; i++) mbusy[i] = 0;
    mwr = 0; mrd = 0; mval = 0; merr = 0; mfav_alu = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 31));
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = (cyc % 3 == 0) ? mrd : 5'($urandom_range(0, 31));
      if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1'b1; a_rd = pick_rd(); a_val = $urandom;
      end
      if (!m_valid && $urandom_range(0, 2) == 0) begin
        m_valid = 1'b1; m_rd = pick_rd(); m_val = $urandom;
      end
      #1;
      e_iss = (iss_rd == 0) || !mbusy[iss_rd];
      e_rs1 = mbusy[chk_rs1];
      e_rs2 = mbusy[chk_rs2];
`ifdef WB_SCHED_BYPASS_EN
      if (mwr && mrd != 0 && mrd == chk_rs1) e_rs1 = 1'b0;
      if (mwr && mrd != 0 && mrd == chk_rs2) e_rs2 = 1'b0;
`endif
      if (a_valid && m_valid) begin
        e_a = mfav_alu;
        e_m = !mfav_alu;
        mfav_alu = !mfav_alu;
      end else begin
        e_a = a_valid;
        e_m = m_valid;
      end
      tests_run++;
      if (iss_ready !== e_iss || rs1_busy !== e_rs1 || rs2_busy !== e_rs2) begin
        tests_failed++;
        $display("[TB] FAIL rand_hazard cyc %0d: iss_ready=%b rs1=%b rs2=%b want %b/%b/%b",
                 cyc, iss_ready, rs1_busy, rs2_busy, e_iss, e_rs1, e_rs2);
      end
      tests_run++;
      if (a_ready !== e_a || m_ready !== e_m) begin
        tests_failed++;
        $display("[TB] FAIL rand_arb cyc %0d: a_ready=%b m_ready=%b want %b/%b", cyc, a_ready, m_ready, e_a, e_m);
      end
      g_any = e_a || e_m;
      g_rd  = e_m ? m_rd : a_rd;
      g_val = e_m ? m_val : a_val;
      a_fire = e_a;
      m_fire = e_m;
      ob = mbusy;
      if (mwr) mbusy[mrd] = 0;
      if (iss_valid && e_iss && iss_rd != 0) mbusy[iss_rd] = 1;
      if (g_any) begin
        if (g_rd != 0 && !ob[g_rd]) merr = 1'b1;
        mwr  = (g_rd != 0);
        mrd  = g_rd;
        mval = g_val;
      end else begin
        mwr = 1'b0;
      end
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += int'(mbusy[i]);
      @(posedge clk);
      #1;
      if (a_fire) a_valid = 1'b0;
      if (m_fire) m_valid = 1'b0;
      tests_run++;
      if (wr_en !== mwr || busy_cnt !== 6'(cnt) || err !== merr) begin
        tests_failed++;
        $display("[TB] FAIL rand_regs cyc %0d: wr_en=%b cnt=%0d err=%b want %b/%0d/%b",
                 cyc, wr_en, busy_cnt, err, mwr, cnt, merr);
      end
      if (mwr) begin
        tests_run++;
        if (rd !== mrd || rd_val !== mval) begin
          tests_failed++;
          $display("[TB] FAIL rand_port cyc %0d: rd=%0d val=%h want %0d/%h", cyc, rd, rd_val, mrd, mval);
        end
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    chk_rs1      = 5'd0;
    chk_rs2      = 5'd0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_issue_waw();
    test_writeback();
    test_conflict();
    test_x0_unissued();
    test_reset_mid();
`ifdef WB_SCHED_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
